m68k_bus_bridge: RTL
====================

// Module: m68k_bus_bridge
// PURPOSE
//  Front end between the asynchronous MC68000 pins and the internal synchronous bus
//  (addr/data_write/data_read/uds/lds/rw/ack) feeding boot_device and sram_if.
//  - Synchronises AS_n/UDS_n/LDS_n and launches one internal cycle per CPU bus cycle.
//  - Waits for ack, returns read data and drives DTACK_n back to the CPU.
//  - Guarantees that the internal strobes fall between cycles, so downstream
//    edge detectors see every cycle end.
// PARAMETERS
//  SYNC_STAGES     2    flip-flop stages on cpu_as_n/cpu_uds_n/cpu_lds_n (>=2)
//  TIMEOUT_CYCLES  255  clk cycles waiting for bus_ack before BERR (macro builds only)
//  TO_W            8    timeout counter width; 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clk             in   1   system clock; only clock in the block
//  reset           in   1   synchronous, active-high reset
//  cpu_as_n        in   1   68000 address strobe (async)
//  cpu_uds_n       in   1   68000 upper data strobe, D[15:8], even byte (async)
//  cpu_lds_n       in   1   68000 lower data strobe, D[7:0], odd byte (async)
//  cpu_rw          in   1   1=read, 0=write
//  cpu_addr        in   23  A[23:1]
//  cpu_data_in     in   16  D[15:0] from CPU (writes)
//  cpu_data_out    out  16  read data to CPU
//  cpu_data_oe     out  1   1=drive D[15:0] toward CPU
//  cpu_dtack_n     out  1   data transfer acknowledge, active low
//  cpu_berr_n      out  1   bus error, active low
//  bus_addr        out  24  {cpu_addr,1'b0}, latched per cycle
//  bus_data_write  out  16  latched write data
//  bus_data_read   in   16  read data from downstream
//  bus_uds         out  1   active-high upper strobe
//  bus_lds         out  1   active-high lower strobe
//  bus_rw          out  1   latched cpu_rw
//  bus_ack         in   1   level ack from downstream
// BEHAVIOUR
//  Reset (sync, 1 edge): state=IDLE; bus_uds=bus_lds=0; bus_rw=1;
//   bus_addr=0; bus_data_write=0; cpu_data_out=0; cpu_data_oe=0;
//   cpu_dtack_n=1; cpu_berr_n=1; timeout counter=0. Applies from any state.
//  as_s/ds_s denote synchronised, active-high AS and (UDS|LDS).
//  IDLE: as_s && ds_s -> at that edge latch bus_addr, bus_rw, bus_data_write, and
//   bus_uds/bus_lds from synced strobes. -> BUS. AS alone (write before DS): stay.
//  BUS: strobes held at latched values. bus_ack=1 -> strobes 0 next edge;
//   if rw=1, cpu_data_out<=bus_data_read; cpu_dtack_n<=0; cpu_data_oe<=bus_rw. -> ACK.
//   as_s=0 (aborted cycle) -> strobes 0, no DTACK. -> IDLE.
//  ACK: hold DTACK/data until as_s=0 && ds_s=0 -> dtack_n=1, oe=0. -> IDLE.
//  Latency: raw DS assert -> bus strobe = SYNC_STAGES+1 clk; bus_ack -> DTACK low = 1 clk.
//  Strobes are 0 in ACK/IDLE, so they are low >=1 clk between back-to-back cycles.
//  bus_addr/bus_rw/bus_data_write are stable for the whole time strobes are 1.
//  ack and as_s falling at the same edge in BUS: ack wins -> ACK. ACK then exits
//   once strobes are released.
//  bus_ack ignored outside BUS.
// CONFIGURATION
//  M68K_BRIDGE_BERR_EN defined:
//   - BUS counts clk cycles (reset to 0 on BUS entry).
//   - Count == TIMEOUT_CYCLES without ack -> strobes 0, cpu_berr_n=0, -> ERR.
//   - ERR holds berr_n=0, dtack_n=1 until as_s=0 && ds_s=0. -> IDLE.
//   - Ack at the timeout edge wins.
//  Undefined: no counter, no ERR state; BUS waits indefinitely;
//   cpu_berr_n constant 1.
// TESTING
//  1 Word read A=0x000100, ack 2 clk after strobes, data 0x4E71 -> bus_uds=bus_lds=1,
//    bus_rw=1, bus_addr=0x000100; DTACK_n low 1 clk after ack; cpu_data_out=0x4E71, oe=1
//    until AS_n/DS_n high.
//  2 Upper byte write A=0x001000, D=0xA5xx, UDS only -> bus_uds=1, bus_lds=0, bus_rw=0,
//    data_write=0xA5xx; oe stays 0; DTACK_n low after ack.
//  3 Back-to-back reads at 0x0 and 0x2 -> strobes 0 for >=1 clk between cycles;
//    two DTACKs.
//  4 With M68K_BRIDGE_BERR_EN and no ack -> after 255 clk in BUS: berr_n=0, dtack_n=1,
//    strobes 0. Without macro -> berr_n stays 1, strobes held indefinitely.
//  5 Reset pulsed while in BUS -> next edge all outputs at reset values; new cycle
//    after reset completes normally.
//  6 AS_n released in BUS before ack -> strobes 0, DTACK_n never asserted, back in IDLE.

Source files
------------

// File: rtl/m68k_bus_bridge_if.sv
// Signal bundle between the MC68000 pins, the bridge and the internal synchronous bus.
// master: bridge side (drives bus_* and the CPU-facing returns); slave: CPU pins and downstream devices.
interface m68k_bus_bridge_if;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;
    logic [23:0] bus_addr;
    logic [15:0] bus_data_write;
    logic [15:0] bus_data_read;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_rw;
    logic        bus_ack;

    modport master (
        input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in,
        output cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_berr_n,
        output bus_addr, bus_data_write, bus_uds, bus_lds, bus_rw,
        input  bus_data_read, bus_ack
    );

    modport slave (
        output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in,
        input  cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_berr_n,
        input  bus_addr, bus_data_write, bus_uds, bus_lds, bus_rw,
        output bus_data_read, bus_ack
    );
endinterface

// File: rtl/m68k_bus_bridge.sv
// MC68000 asynchronous bus to internal synchronous bus bridge, one internal cycle per CPU cycle.
// Define M68K_BRIDGE_BERR_EN to add the bus_ack timeout that raises BERR.
module m68k_bus_bridge #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    m68k_bus_bridge_if.master  bif
);

`ifdef M68K_BRIDGE_BERR_EN
    typedef enum logic [1:0] {IDLE, BUS, ACK, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;
`endif

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] as_sync_q, uds_sync_q, lds_sync_q;
    logic as_s, uds_s, lds_s, ds_s;

    logic [23:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_data_write_q, bus_data_write_d;
    logic        bus_uds_q, bus_uds_d;
    logic        bus_lds_q, bus_lds_d;
    logic        bus_rw_q, bus_rw_d;
    logic [15:0] cpu_data_out_q, cpu_data_out_d;
    logic        cpu_data_oe_q, cpu_data_oe_d;
    logic        cpu_dtack_n_q, cpu_dtack_n_d;
`ifdef M68K_BRIDGE_BERR_EN
    logic            cpu_berr_n_q, cpu_berr_n_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            as_sync_q  <= '0;
            uds_sync_q <= '0;
            lds_sync_q <= '0;
        end else begin
            as_sync_q  <= {as_sync_q[SYNC_STAGES-2:0],  ~bif.cpu_as_n};
            uds_sync_q <= {uds_sync_q[SYNC_STAGES-2:0], ~bif.cpu_uds_n};
            lds_sync_q <= {lds_sync_q[SYNC_STAGES-2:0], ~bif.cpu_lds_n};
        end
    end

    assign as_s  = as_sync_q[SYNC_STAGES-1];
    assign uds_s = uds_sync_q[SYNC_STAGES-1];
    assign lds_s = lds_sync_q[SYNC_STAGES-1];
    assign ds_s  = uds_s | lds_s;

    always_comb begin
        state_d          = state_q;
        bus_addr_d       = bus_addr_q;
        bus_data_write_d = bus_data_write_q;
        bus_uds_d        = bus_uds_q;
        bus_lds_d        = bus_lds_q;
        bus_rw_d         = bus_rw_q;
        cpu_data_out_d   = cpu_data_out_q;
        cpu_data_oe_d    = cpu_data_oe_q;
        cpu_dtack_n_d    = cpu_dtack_n_q;
`ifdef M68K_BRIDGE_BERR_EN
        cpu_berr_n_d     = cpu_berr_n_q;
        to_cnt_d         = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Writes assert AS before DS; wait for both so write data is valid.
                if (as_s && ds_s) begin
                    bus_addr_d       = {bif.cpu_addr, 1'b0};
                    bus_rw_d         = bif.cpu_rw;
                    bus_data_write_d = bif.cpu_data_in;
                    bus_uds_d        = uds_s;
                    bus_lds_d        = lds_s;
`ifdef M68K_BRIDGE_BERR_EN
                    to_cnt_d         = '0;
`endif
                    state_d          = BUS;
                end
            end
            BUS: begin
                // Priority: ack, then abort, then timeout.
                if (bif.bus_ack) begin
                    bus_uds_d     = 1'b0;
                    bus_lds_d     = 1'b0;
                    if (bus_rw_q) cpu_data_out_d = bif.bus_data_read;
                    cpu_dtack_n_d = 1'b0;
                    cpu_data_oe_d = bus_rw_q;
                    state_d       = ACK;
                end else if (!as_s) begin
                    bus_uds_d = 1'b0;
                    bus_lds_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef M68K_BRIDGE_BERR_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                    bus_uds_d    = 1'b0;
                    bus_lds_d    = 1'b0;
                    cpu_berr_n_d = 1'b0;
                    state_d      = ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ACK: begin
                if (!as_s && !ds_s) begin
                    cpu_dtack_n_d = 1'b1;
                    cpu_data_oe_d = 1'b0;
                    state_d       = IDLE;
                end
            end
`ifdef M68K_BRIDGE_BERR_EN
            ERR: begin
                if (!as_s && !ds_s) begin
                    cpu_berr_n_d = 1'b1;
                    state_d      = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            bus_addr_q       <= '0;
            bus_data_write_q <= '0;
            bus_uds_q        <= 1'b0;
            bus_lds_q        <= 1'b0;
            bus_rw_q         <= 1'b1;
            cpu_data_out_q   <= '0;
            cpu_data_oe_q    <= 1'b0;
            cpu_dtack_n_q    <= 1'b1;
`ifdef M68K_BRIDGE_BERR_EN
            cpu_berr_n_q     <= 1'b1;
            to_cnt_q         <= '0;
`endif
        end else begin
            state_q          <= state_d;
            bus_addr_q       <= bus_addr_d;
            bus_data_write_q <= bus_data_write_d;
            bus_uds_q        <= bus_uds_d;
            bus_lds_q        <= bus_lds_d;
            bus_rw_q         <= bus_rw_d;
            cpu_data_out_q   <= cpu_data_out_d;
            cpu_data_oe_q    <= cpu_data_oe_d;
            cpu_dtack_n_q    <= cpu_dtack_n_d;
`ifdef M68K_BRIDGE_BERR_EN
            cpu_berr_n_q     <= cpu_berr_n_d;
            to_cnt_q         <= to_cnt_d;
`endif
        end
    end

    assign bif.bus_addr       = bus_addr_q;
    assign bif.bus_data_write = bus_data_write_q;
    assign bif.bus_uds        = bus_uds_q;
    assign bif.bus_lds        = bus_lds_q;
    assign bif.bus_rw         = bus_rw_q;
    assign bif.cpu_data_out   = cpu_data_out_q;
    assign bif.cpu_data_oe    = cpu_data_oe_q;
    assign bif.cpu_dtack_n    = cpu_dtack_n_q;
`ifdef M68K_BRIDGE_BERR_EN
    assign bif.cpu_berr_n     = cpu_berr_n_q;
`else
    assign bif.cpu_berr_n     = 1'b1;
`endif

endmodule
